// File: rtl/bf16_pkg.sv
// Shared bfloat16 constants and field classifiers.
// Used by the logit collector and the max-find datapath.
package bf16_pkg;

   localparam int BF16_W = 16;
   localparam int EXP_W  = 8;
   localparam int MANT_W = 7;

   localparam logic [BF16_W-1:0] BF16_NEG_INF  = 16'hFF80;
   localparam logic [BF16_W-1:0] BF16_POS_ZERO = 16'h0000;
   localparam logic [BF16_W-1:0] BF16_EXP_MASK = 16'h7F80;
   localparam logic [BF16_W-1:0] BF16_MAN_MASK = 16'h007F;

   function automatic logic bf16_is_nan(input logic [BF16_W-1:0] x);
      return ((x & BF16_EXP_MASK) == BF16_EXP_MASK) &&
             ((x & BF16_MAN_MASK) != '0);
   endfunction

   function automatic logic bf16_exp_zero(input logic [BF16_W-1:0] x);
      return (x & BF16_EXP_MASK) == '0;
   endfunction

endpackage

// File: rtl/bf16_logit_collector_if.sv
// Serial logit input stream plus parallel frame output handshake.
interface bf16_logit_collector_if
   import bf16_pkg::*;
#(
   parameter int NUM_OUT = 10
);

   logic                      in_valid;
   logic [BF16_W-1:0]         in_data;
   logic                      in_last;
   logic                      in_ready;
   logic                      out_valid;
   logic                      out_ready;
   logic [BF16_W*NUM_OUT-1:0] out_logits;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_logits
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_logits
   );

endinterface

// File: rtl/bf16_sanitize.sv
// Maps NaN to -inf and flushes zero-exponent values (incl. -0) to +0,
// so the downstream equality match sees one encoding per value.
module bf16_sanitize
   import bf16_pkg::*;
#(
   parameter bit FLUSH_SUBNORM = 1'b1,
   parameter bit NAN_TO_NEGINF = 1'b1
) (
   input  logic [BF16_W-1:0] din,
   output logic [BF16_W-1:0] dout
);

   always_comb begin
      dout = din;
      if (NAN_TO_NEGINF && bf16_is_nan(din))
         dout = BF16_NEG_INF;
      else if (FLUSH_SUBNORM && bf16_exp_zero(din))
         dout = BF16_POS_ZERO;
   end

endmodule

// File: rtl/bf16_logit_collector.sv
// Collects one frame of serial bf16 logits and holds it in parallel
// until the max-find stage takes it.
module bf16_logit_collector
   import bf16_pkg::*;
#(
   parameter int NUM_OUT       = 10,
   parameter bit FLUSH_SUBNORM = 1'b1,
   parameter bit NAN_TO_NEGINF = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   bf16_logit_collector_if.slave bus,
   output logic                 frame_err,
   output logic [15:0]          frame_cnt
);

   localparam int IDX_W = $clog2(NUM_OUT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

   localparam logic [0:0] FILL = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   logic [0:0]        state;
   logic [IDX_W-1:0]  idx;
   logic [BF16_W-1:0] slot [NUM_OUT];
   logic [BF16_W-1:0] san;
   logic              accept;

   bf16_sanitize #(
      .FLUSH_SUBNORM (FLUSH_SUBNORM),
      .NAN_TO_NEGINF (NAN_TO_NEGINF)
   ) u_san (
      .din  (bus.in_data),
      .dout (san)
   );

   assign bus.in_ready  = (state == FILL);
   assign bus.out_valid = (state == HOLD);
   assign accept        = bus.in_valid & bus.in_ready;

   always_comb begin
      bus.out_logits = '0;
      for (int i = 0; i < NUM_OUT; i++)
         bus.out_logits[BF16_W*i +: BF16_W] = slot[i];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= FILL;
         idx       <= '0;
         frame_err <= 1'b0;
         frame_cnt <= '0;
         for (int i = 0; i < NUM_OUT; i++)
            slot[i] <= '0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            FILL: begin
               if (accept) begin
                  // a short frame pads the unfilled tail with -inf
                  for (int i = 0; i < NUM_OUT; i++) begin
                     if (IDX_W'(i) == idx)
                        slot[i] <= san;
                     else if (bus.in_last && (IDX_W'(i) > idx))
                        slot[i] <= BF16_NEG_INF;
                  end
                  if (idx == LAST_IDX) begin
                     state     <= HOLD;
                     frame_err <= ~bus.in_last;
                  end else if (bus.in_last) begin
                     state     <= HOLD;
                     frame_err <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: begin
               if (bus.out_ready) begin
                  state     <= FILL;
                  idx       <= '0;
                  frame_cnt <= frame_cnt + 16'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bf16_logit_collector.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge
// monitor pops and compares at every frame handoff.
module tb_bf16_logit_collector;
   import bf16_pkg::*;

   localparam int N = 10;
   localparam int W = 16 * N;

   typedef logic [15:0] vec_t [N];
   typedef struct packed {
      logic [W-1:0] logits;
      logic         err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_err;
   logic [15:0] frame_cnt;

   always #5 clk = ~clk;

   bf16_logit_collector_if #(.NUM_OUT(N)) bus();

   bf16_logit_collector #(
      .NUM_OUT       (N),
      .FLUSH_SUBNORM (1'b1),
      .NAN_TO_NEGINF (1'b1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .frame_err (frame_err),
      .frame_cnt (frame_cnt)
   );

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int          rmode = 1;
   logic [15:0] hand_cnt = '0;
   int          err_seen = 0;
   logic        prev_err = 1'b0;

   vec_t t1 = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0,
                16'h40C0, 16'h40E0, 16'h4100, 16'h4110, 16'h4120};
   vec_t t2 = '{16'hBF80, 16'h4000, 16'hC040, 16'h3F00, 16'h4248,
                16'h4120, 16'hC120, 16'h3E80, 16'h42C8, 16'hC2C8};
   vec_t t3 = '{16'h4120, 16'h4110, 16'h4100, 16'h40E0, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
   vec_t e3 = '{16'h4120, 16'h4110, 16'h4100, 16'h40E0, 16'hFF80,
                16'hFF80, 16'hFF80, 16'hFF80, 16'hFF80, 16'hFF80};
   vec_t t4 = '{16'h4120, 16'h4110, 16'h4100, 16'h40E0, 16'h40C0,
                16'h40A0, 16'h4080, 16'h4040, 16'h4000, 16'h3F80};
   vec_t t5 = '{16'h7FC1, 16'h8000, 16'h0005, 16'h7F80, 16'hFF80,
                16'h807F, 16'h3F80, 16'hFFC0, 16'h0080, 16'hBF80};
   vec_t e5 = '{16'hFF80, 16'h0000, 16'h0000, 16'h7F80, 16'hFF80,
                16'h0000, 16'h3F80, 16'hFF80, 16'h0080, 16'hBF80};

   function automatic logic [W-1:0] pack(input vec_t v);
      logic [W-1:0] p = '0;
      for (int i = 0; i < N; i++) p[16*i +: 16] = v[i];
      return p;
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // consumer drives out_ready a little after each rising edge
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (rmode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            hand_cnt = '0;
            err_seen = 0;
            prev_err = 1'b0;
         end else begin
            if (frame_err) begin
               err_seen++;
               chk("err_pulse_width", W'(prev_err), W'(0));
            end
            prev_err = frame_err;
            if (bus.out_valid && bus.out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_frame", W'(1), W'(0));
               end else begin
                  e = sb.pop_front();
                  chk("frame_logits", bus.out_logits, e.logits);
                  chk("frame_err_cnt", W'(err_seen), W'(e.err));
                  chk("frame_cnt", W'(frame_cnt), W'(hand_cnt));
               end
               hand_cnt = hand_cnt + 16'd1;
               err_seen = 0;
            end
         end
      end
   end

   task automatic beat(input logic [15:0] d, input logic last,
                       input int gap);
      logic acc = 1'b0;
      bus.in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
      end
      chk("beat_accept", W'(acc), W'(1));
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic send_frame(input vec_t v, input int n, input int last_at,
                             input vec_t ev, input logic eerr,
                             input bit rnd);
      exp_t e;
      for (int i = 0; i < n; i++)
         beat(v[i], 1'(i == last_at), rnd ? int'($urandom_range(0, 2)) : 0);
      e.logits = pack(ev);
      e.err    = eerr;
      sb.push_back(e);
      @(negedge clk);
      chk("latency_out_valid", W'(bus.out_valid), W'(1));
      chk("err_at_close", W'(frame_err), W'(eerr));
      @(posedge clk);
      #1;
   endtask

   initial begin
      bool_done: begin end
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", W'(bus.in_ready), W'(1));
      chk("rst_out_valid", W'(bus.out_valid), W'(0));
      chk("rst_logits", bus.out_logits, W'(0));
      chk("rst_frame_err", W'(frame_err), W'(0));
      chk("rst_frame_cnt", W'(frame_cnt), W'(0));
      @(posedge clk);
      #1;

      send_frame(t1, 10, 9, t1, 1'b0, 1'b0);
      @(negedge clk);
      chk("t1_frame_cnt", W'(frame_cnt), W'(1));
      chk("t1_valid_drop", W'(bus.out_valid), W'(0));
      @(posedge clk);
      #1;

      rmode = 0;
      send_frame(t2, 10, 9, t2, 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h1234;
      repeat (20) begin
         @(negedge clk);
         chk("hold_in_ready", W'(bus.in_ready), W'(0));
         chk("hold_logits", bus.out_logits, pack(t2));
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      rmode = 1;
      @(posedge clk);
      @(negedge clk);
      chk("release_valid", W'(bus.out_valid), W'(0));
      chk("release_in_ready", W'(bus.in_ready), W'(1));
      @(posedge clk);
      #1;

      send_frame(t3, 4, 3, e3, 1'b1, 1'b0);
      send_frame(t1, 10, -1, t1, 1'b1, 1'b0);
      send_frame(t4, 10, 9, t4, 1'b0, 1'b0);
      send_frame(t5, 10, 9, e5, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) beat(t2[i], 1'b0, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", W'(bus.out_valid), W'(0));
      chk("midrst_logits", bus.out_logits, W'(0));
      chk("midrst_in_ready", W'(bus.in_ready), W'(1));
      chk("midrst_frame_cnt", W'(frame_cnt), W'(0));
      @(posedge clk);
      #1;
      send_frame(t1, 10, 9, t1, 1'b0, 1'b0);
      rmode = 2;
      send_frame(t1, 10, 9, t1, 1'b0, 1'b1);
      send_frame(t5, 10, 9, e5, 1'b0, 1'b1);
      rmode = 1;

      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      chk("sb_drained", W'(sb.size()), W'(0));
      chk("final_frame_cnt", W'(frame_cnt), W'(3));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
